// File: rtl/adder_pkg.sv
// adder_pkg -- shared definitions for the adder operand pairer.
//
// Holds the default word width, the pairing FSM state encoding and the
// operand-pair record that travels through the pair FIFO.
package adder_pkg;

  localparam int DATA_W_DEFAULT = 32;

  // WAIT_A: no operand held.  WAIT_B: operand A held, waiting for B.
  typedef enum logic {
    WAIT_A = 1'b0,
    WAIT_B = 1'b1
  } state_e;

  // One operand pair as presented to the downstream adder.
  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] a;
    logic [DATA_W_DEFAULT-1:0] b;
    logic                      last;  // final pair of a frame
    logic                      odd;   // b is zero padding
  } pair_t;

endpackage

// File: rtl/adder_pair_fifo.sv
// adder_pair_fifo -- small circular FIFO of operand pairs.
//
// Parameters:
//   DEPTH    number of entries, 2..8
//   entry_t  stored record type (defaults to adder_pkg::pair_t)
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous active-low reset
//   push       write push_data this cycle (caller only pushes while ready)
//   push_data  entry to write
//   pop        consume the head entry this cycle (ignored when empty)
//   ready      registered "occupancy < DEPTH"; no path from pop
//   valid      occupancy != 0
//   head       entry at the read pointer
module adder_pair_fifo
  import adder_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = pair_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output logic   ready,
  output logic   valid,
  output entry_t head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             do_push, do_pop;

  assign do_push = push && ready_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      // pointers wrap modulo DEPTH, which need not be a power of two
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;  // idle, or push+pop leaves occupancy alone
    endcase

    // ready is registered from the next occupancy so the upstream handshake
    // never sees a combinational path from pop/out_ready.
    ready_d = (count_d < DEPTH_C);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  assign ready = ready_q;
  assign valid = (count_q != '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/adder_operand_pairer.sv
// adder_operand_pairer -- groups an upstream word stream into operand pairs
// for a downstream adder.
//
// Consecutive words of a frame become (a, b) pairs.  A frame with an odd
// word count ends in a pair whose b is zero padding, flagged by out_odd.
// Pairs are queued in a DEPTH-entry FIFO; output fields come straight from
// the FIFO head, so a pair appears one cycle after it is formed.
//
// Parameters:
//   DATA_W  operand / word width (default adder_pkg::DATA_W_DEFAULT)
//   DEPTH   pair FIFO entries, 2..8
//
// Ports:
//   clock, reset          single clock; synchronous active-low reset
//   in_valid/in_ready     upstream handshake; in_ready is registered state
//   in_data, in_last      upstream word and end-of-frame marker
//   out_valid/out_ready   downstream handshake
//   out_a, out_b          operand pair
//   out_last              final pair of a frame
//   out_odd               out_b is zero padding
//   pair_count            pairs popped, wraps at 16 bits
//                         (only when ADDER_PAIRER_STATS_EN is defined)
//
// Build option: ADDER_PAIRER_STATS_EN adds pair_count and its counter.
module adder_operand_pairer
  import adder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last,
  output logic              out_odd
`ifdef ADDER_PAIRER_STATS_EN
  ,
  output logic [15:0]       pair_count
`endif
);

  // Same layout as adder_pkg::pair_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
    logic              odd;
  } pair_w_t;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              accept;
  logic              push;
  pair_w_t           push_data;
  logic              pop;
  logic              fifo_ready;
  logic              fifo_valid;
  pair_w_t           head;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    push      = 1'b0;
    push_data = '0;

    if (accept) begin
      case (state_q)
        WAIT_A: begin
          if (in_last) begin
            // lone final word: pad b with zero
            push      = 1'b1;
            push_data = '{a: in_data, b: '0, last: 1'b1, odd: 1'b1};
          end else begin
            a_d     = in_data;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          push      = 1'b1;
          push_data = '{a: a_q, b: in_data, last: in_last, odd: 1'b0};
          a_d       = '0;
          state_d   = WAIT_A;
        end
        default: begin
          state_d = WAIT_A;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= WAIT_A;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  adder_pair_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (pair_w_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .ready     (fifo_ready),
    .valid     (fifo_valid),
    .head      (head)
  );

  assign in_ready  = fifo_ready;
  assign out_valid = fifo_valid;
  assign out_a     = head.a;
  assign out_b     = head.b;
  assign out_last  = head.last;
  assign out_odd   = head.odd;

`ifdef ADDER_PAIRER_STATS_EN
  logic [15:0] pair_count_q, pair_count_d;

  always_comb begin
    pair_count_d = pair_count_q;
    if (pop) pair_count_d = pair_count_q + 16'd1;  // wraps 0xFFFF -> 0
  end

  always_ff @(posedge clock) begin
    if (!reset) pair_count_q <= '0;
    else        pair_count_q <= pair_count_d;
  end

  assign pair_count = pair_count_q;
`endif

endmodule

// File: doc/adder_operand_pairer.md
ADDER_OPERAND_PAIRER -- requirements
Module: adder_operand_pairer

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand and word width.
REQ-002 Parameter DEPTH, default 2, SHALL set the number of operand-pair FIFO entries; legal values are 2..8.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on posedge clock.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset; asserted when reset==0 at a rising edge of clock.
REQ-005 in_valid  input  1  SHALL indicate an upstream word is offered.
REQ-006 in_ready  output  1  SHALL indicate the block accepts the offered word this cycle.
REQ-007 in_data  input  DATA_W  SHALL carry the upstream word.
REQ-008 in_last  input  1  SHALL mark the final word of a frame.
REQ-009 out_valid  output  1  SHALL indicate an operand pair is presented to the downstream adder.
REQ-010 out_ready  input  1  SHALL indicate the adder consumes the presented pair.
REQ-011 out_a, out_b  output  DATA_W each  SHALL carry the operand pair.
REQ-012 out_last  output  1  SHALL mark the final pair of a frame.
REQ-013 out_odd  output  1  SHALL flag a pair whose out_b is zero-padding.
REQ-014 pair_count  output  16  SHALL report the number of pairs popped; present only under ADDER_PAIRER_STATS_EN.

Function
REQ-015 A transfer SHALL occur on a cycle with valid and ready both high, on each side independently.
REQ-016 The FSM SHALL have two states: WAIT_A (holding no operand) and WAIT_B (holding operand A).
REQ-017 In WAIT_A, an accepted word with in_last=0 SHALL be latched as A, with transition to WAIT_B.
REQ-018 In WAIT_A, an accepted word with in_last=1 SHALL push {a=word, b=0, last=1, odd=1} and stay in WAIT_A.
REQ-019 In WAIT_B, an accepted word SHALL push {a=A, b=word, last=in_last, odd=0} and return to WAIT_A.
REQ-020 in_ready SHALL equal (FIFO occupancy < DEPTH), registered-state only, with no combinational path from out_ready.
REQ-021 out_valid SHALL equal (occupancy != 0); out_a, out_b, out_last and out_odd SHALL come from the FIFO head register.
REQ-022 Latency SHALL be 1 cycle: a push at edge N with an empty FIFO gives out_valid=1 after edge N.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 Presented outputs SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 pair_count SHALL increment by 1 per pop and wrap from 0xFFFF to 0.

Reset
REQ-027 While reset==0 at an edge, the block SHALL set FSM=WAIT_A, occupancy=0, pointers=0, held A=0 and pair_count=0.
REQ-028 Reset SHALL give out_valid=0, in_ready=0 during the reset cycle, out_a/out_b/out_last/out_odd=0, and in_ready=1 on the first cycle after release.
REQ-029 A reset mid-frame SHALL discard the held operand A and all queued pairs without emitting them.

Configuration
REQ-030 With ADDER_PAIRER_STATS_EN defined, the pair_count port and its counter SHALL exist.
REQ-031 Without ADDER_PAIRER_STATS_EN, the pair_count port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 The shared package adder_pkg SHALL hold DATA_W_DEFAULT=32, the FSM state enum (WAIT_A, WAIT_B) and the pair struct {a, b, last, odd}.
REQ-033 The FIFO SHALL be a sub-module, adder_pair_fifo, parameterised by DEPTH and holding adder_pkg pair entries.

Verification
REQ-034 Words 5,7 (last on 7) with out_ready=1 -> one pair a=5, b=7, last=1, odd=0, valid 1 cycle after the second accept.
REQ-035 Words 9,4,3 (last on 3) -> pairs (9,4,last=0,odd=0), then (3,0,last=1,odd=1).
REQ-036 out_ready=0 with 5 words offered, DEPTH=2 -> two pairs queued, in_ready=0, outputs stable; raising out_ready drains in order.
REQ-037 Push and pop on the same cycle at occupancy 1 -> occupancy stays 1 and order is preserved across 20 back-to-back pairs.
REQ-038 Reset asserted in WAIT_B after word 11 -> no pair emitted; next words 1,2 (last) give pair (1,2).
REQ-039 With STATS_EN, 65537 pops -> pair_count=1; without STATS_EN, the build elaborates with no pair_count port.
